// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Memory-mapped UART transmitter that sits in the processor's dmem path.
// Address 12'hFFF (TXDATA) pushes a byte into a small TX FIFO. Address 12'hFFE (STATUS)
// returns a registered status word. Every other address passes straight through to the dmem RAM.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   FIFO_DEPTH    TX FIFO entries (power of two, >= 2)
// Ports:
//   clock         single clock; all state changes on its rising edge
//   reset         synchronous, active-high
//   address_dmem  processor dmem address
//   data          processor dmem write data (bits [7:0] carry the TX byte)
//   wren          processor dmem write enable
//   q_dmem_ram    read data from the synchronous dmem RAM
//   wren_ram      write enable to the RAM, suppressed for the two UART addresses
//   q_dmem        read data returned to the processor (status snapshot or RAM data)
//   uart_tx       registered serial output, idle high
//   tx_busy       high while the FIFO holds data or a frame is being sent
// Status word layout:
//   bit0  full
//   bit1  empty
//   bit2  serializer active
//   bit3  sticky overflow
//   [7:4] FIFO count
module mmio_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    input  logic [31:0] q_dmem_ram,
    output logic        wren_ram,
    output logic [31:0] q_dmem,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [15:0]      BIT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Address decode and bus-side controls
    logic             addr_txdata_s;
    logic             addr_status_s;
    logic             push_s;
    logic             ovf_set_s;
    logic             ovf_clr_s;
    logic             unused_data_s;

    // FIFO
    logic [7:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;

    // Status readback
    logic             overflow_r;
    logic             sel_status_r;
    logic [31:0]      snapshot_r;
    logic [31:0]      status_s;

    // Serializer
    tx_state_t        state_r;
    tx_state_t        state_next_s;
    logic [15:0]      bit_cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             bit_end_s;
    logic             tx_next_s;
    logic             busy_next_s;
    logic             uart_tx_r;
    logic             tx_busy_r;

    assign addr_txdata_s = (address_dmem == 12'hFFF);
    assign addr_status_s = (address_dmem == 12'hFFE);
    assign full_s        = (count_r == CNT_FULL);
    assign empty_s       = (count_r == CNT_ZERO);
    // A full FIFO rejects the write even if the serializer pops on the same edge.
    assign push_s        = wren & addr_txdata_s & ~full_s;
    assign ovf_set_s     = wren & addr_txdata_s & full_s;
    assign ovf_clr_s     = wren & addr_status_s;
    assign wren_ram      = wren & ~addr_txdata_s & ~addr_status_s;
    assign bit_end_s     = (bit_cnt_r == BIT_LAST);
    // Only the low byte of the write data is transmitted.
    assign unused_data_s = ^data[31:8];

    assign status_s = ((32'(count_r) << 4) & 32'h0000_00F0)
                    | {28'h000_0000, overflow_r, (state_r != ST_IDLE), empty_s, full_s};

    assign q_dmem  = sel_status_r ? snapshot_r : q_dmem_ram;
    assign uart_tx = uart_tx_r;
    assign tx_busy = tx_busy_r;

    // FIFO count update for the push/pop combination of this cycle
    always_comb begin
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= data[7:0];
        end
    end

    // FIFO pointers, count, sticky overflow and the status readback registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= CNT_ZERO;
            overflow_r   <= 1'b0;
            sel_status_r <= 1'b0;
            snapshot_r   <= 32'h0000_0000;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            // Set wins over a same-edge clear.
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr_s) begin
                overflow_r <= 1'b0;
            end
            sel_status_r <= addr_status_s;
            snapshot_r   <= status_s;
        end
    end

    // Serializer state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Serializer next-state logic; the pop happens on the edge that enters START
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_idx_r == 3'd7)) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (bit_end_s && !empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_START;
                end else if (bit_end_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Serializer outputs, computed one edge early so uart_tx and tx_busy are flop outputs
    always_comb begin
        tx_next_s   = 1'b1;
        busy_next_s = (state_next_s != ST_IDLE) || (count_next_s != CNT_ZERO);
        case (state_next_s)
            ST_IDLE:  tx_next_s = 1'b1;
            ST_START: tx_next_s = 1'b0;
            ST_DATA: begin
                // shift_r[0] is the current bit; at a bit boundary inside DATA the next bit is shift_r[1].
                if ((state_r == ST_DATA) && bit_end_s) begin
                    tx_next_s = shift_r[1];
                end else begin
                    tx_next_s = shift_r[0];
                end
            end
            ST_STOP:  tx_next_s = 1'b1;
            default:  tx_next_s = 1'b1;
        endcase
    end

    // Serializer datapath: bit timing, bit index, shift register and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt_r <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            uart_tx_r <= 1'b1;
            tx_busy_r <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) || bit_end_s) begin
                bit_cnt_r <= 16'd0;
            end else begin
                bit_cnt_r <= bit_cnt_r + 16'd1;
            end
            if (state_r != ST_DATA) begin
                bit_idx_r <= 3'd0;
            end else if (bit_end_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end
            if (pop_s) begin
                shift_r <= fifo_mem_r[rd_ptr_r];
            end else if ((state_r == ST_DATA) && bit_end_s) begin
                shift_r <= {1'b0, shift_r[7:1]};
            end
            uart_tx_r <= tx_next_s;
            tx_busy_r <= busy_next_s;
        end
    end

endmodule
